fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined 64-bit RISC-V core, directly upstream of decode and the immediate generator. Holds the PC, presents a fetch address to the combinational instruction memory, and registers the returned word into the IF/ID pipeline register. Decode uses that register to extract the opcode and immediate. The block handles load-use stalls, taken-branch redirect and flush, and end-of-program or fault halting.

## Interface
- RESET_PC, 64'h0: PC value after reset.
- IMEM_BYTES, 1024: instruction-memory size in bytes. The legal fetch range is 0..IMEM_BYTES-4.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit holds the PC and IF/ID.
- branch_taken  in  1  branch resolved taken (from EX).
- branch_target  in  64  redirect address, valid when branch_taken=1.
- imem_addr  out  64  fetch address, combinationally equal to pc.
- imem_rdata  in  32  instruction word at imem_addr (combinational memory).
- pc  out  64  current PC register.
- if_id_instr  out  32  registered instruction for decode.
- if_id_pc  out  64  PC of if_id_instr.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped.
- fault  out  1  halt was caused by a misaligned or out-of-range PC.

## Operation
- FSM states: RUN and HALT. Reset enters RUN.
- Priority at each posedge: reset > branch_taken > stall > normal fetch.
- **reset**:
  - pc=RESET_PC, if_id_instr=32'h00000013 (NOP), if_id_pc=0.
  - if_id_valid=0, halted=0, fault=0, state=RUN.
- **branch_taken=1**, in any state, overriding stall:
  - IF/ID is flushed: instr=NOP, valid=0, if_id_pc=0.
  - If branch_target[1:0]!=0 or branch_target>IMEM_BYTES-4: pc is unchanged, state→HALT, fault=1.
  - Otherwise pc=branch_target, state→RUN, halted=0, fault=0. This recovers from a wrong-path halt.
- **stall=1** (no branch): pc, IF/ID, state and flags all hold.
- **RUN, normal fetch**:
  - If pc>IMEM_BYTES-4: IF/ID receives a bubble, state→HALT, fault=1.
  - Else if imem_rdata==32'h00000000 (end-of-program marker): IF/ID receives a bubble, pc holds, state→HALT, fault=0. The marker never enters IF/ID.
  - Otherwise if_id_instr=imem_rdata, if_id_pc=pc, if_id_valid=1, pc=pc+4.
- **HALT, no branch**:
  - pc holds.
  - IF/ID receives a bubble every cycle.
  - halted=1 persists until reset or branch_taken.
- halted is registered and equals (state==HALT).
- PC arithmetic is 64-bit modulo 2^64. The out-of-range check is evaluated before the increment.

## Timing
- Fetch to IF/ID latency is 1 cycle. imem_addr changes only after a posedge.
- Redirect: with branch_taken at edge N, the target word is fetched in cycle N+1 and is visible in IF/ID after edge N+1. Exactly one bubble follows the flush.
- Halt: the marker fetched at edge N gives halted=1 after edge N. The last valid instruction leaves IF/ID at edge N.
- A bubble is always instr=NOP with valid=0. if_id_pc is don't-care when valid=0, but it is 0 after reset or flush.
- A reset asserted mid-stall, mid-halt or mid-branch wins unconditionally at that edge.

## Test plan
- **Reset**: hold reset 2 cycles with RESET_PC=0x40, then release. Required: pc=0x40, if_id_valid=0, if_id_instr=0x00000013, halted=0.
- **Sequential fetch**: memory returns 0x00500093 at 0x0 and 0x00A00113 at 0x4. Required after edges 1 and 2: if_id_pc=0x0 then 0x4, valid=1, pc=0x8.
- **Stall**: stall=1 for 3 cycles at pc=0x8. Required: pc=0x8 and IF/ID unchanged for all 3 cycles. Release resumes with the 0x8 word.
- **Branch + stall**: branch_taken=1 with target 0x20 and stall=1 on the same edge. Required: pc=0x20, if_id_valid=0. The next edge loads the word at 0x20 with valid=1.
- **Halt and recovery**: word 0x00000000 at 0xC. Required: halted=1, fault=0, pc=0xC, and the bubble persists. A later branch_taken with target 0x0 gives halted=0 and fetch resumes at 0x0.
- **Faults**:
  - branch_target=0x22 → halted=1, fault=1, pc unchanged.
  - With IMEM_BYTES=16, sequential fetch past 0xC → halted=1, fault=1 at pc=0x10.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction memory and
// registers the fetched word into IF/ID, handling stall, branch redirect/flush and halt.
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [63:0] pc,
    output logic [31:0] if_id_instr,
    output logic [63:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fault
);

    localparam logic [63:0] LAST_ADDR = 64'(IMEM_BYTES) - 64'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] END_MARK  = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;

    // A fetch address is unusable when misaligned or beyond the last word of memory.
    function automatic logic bad_addr(input logic [63:0] addr);
        return (addr[1:0] != 2'b00) || (addr > LAST_ADDR);
    endfunction

    // Next-state and next-output selection: branch beats stall beats normal fetch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        if (branch_taken) begin
            instr_d = NOP_INSTR;
            ipc_d   = 64'h0;
            valid_d = 1'b0;
            if (bad_addr(branch_target)) begin
                state_d  = HALT;
                halted_d = 1'b1;
                fault_d  = 1'b1;
            end else begin
                pc_d     = branch_target;
                state_d  = RUN;
                halted_d = 1'b0;
                fault_d  = 1'b0;
            end
        end else if (!stall) begin
            // Every non-fetching outcome below leaves a bubble in IF/ID.
            instr_d = NOP_INSTR;
            ipc_d   = 64'h0;
            valid_d = 1'b0;
            case (state_q)
                RUN: begin
                    if (bad_addr(pc_q)) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                        fault_d  = 1'b1;
                    end else if (imem_rdata == END_MARK) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                        fault_d  = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 64'd4;
                    end
                end
                HALT: begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end
                default: begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                    fault_d  = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            ipc_q    <= 64'h0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ipc_q;
    assign if_id_valid = valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: two instances (1 KiB memory with reset PC 0x40, and a
// 16-byte memory) driven by shared stimulus and checked against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] ipc;
        logic        valid;
        logic        halted;
        logic        fault;
        logic        ipc_chk;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [63:0] tgt = 64'h0;

    logic [63:0] addr_a, pc_a, ipc_a, addr_b, pc_b, ipc_b;
    logic [31:0] rdata_a, instr_a, rdata_b, instr_b;
    logic        valid_a, halted_a, fault_a, valid_b, halted_b, fault_b;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [4];

    int total = 0;
    int bad = 0;

    snap_t ma, mb;
    snap_t qa[$];
    snap_t qb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_a(input logic [63:0] a);
        if (a < 64'd1024) return mem_a[a[9:2]];
        else return 32'hFFFF_FFFF;
    endfunction

    // Beyond the small memory the word reads as the end marker, so a fault must win.
    function automatic logic [31:0] rd_b(input logic [63:0] a);
        if (a < 64'd16) return mem_b[a[3:2]];
        else return 32'h0000_0000;
    endfunction

    assign rdata_a = rd_a(addr_a);
    assign rdata_b = rd_b(addr_b);

    fetch_stage #(.RESET_PC(64'h40), .IMEM_BYTES(1024)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(br), .branch_target(tgt),
        .imem_addr(addr_a), .imem_rdata(rdata_a), .pc(pc_a), .if_id_instr(instr_a),
        .if_id_pc(ipc_a), .if_id_valid(valid_a), .halted(halted_a), .fault(fault_a)
    );

    fetch_stage #(.RESET_PC(64'h0), .IMEM_BYTES(16)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(br), .branch_target(tgt),
        .imem_addr(addr_b), .imem_rdata(rdata_b), .pc(pc_b), .if_id_instr(instr_b),
        .if_id_pc(ipc_b), .if_id_valid(valid_b), .halted(halted_b), .fault(fault_b)
    );

    // Reference model: one clock edge of the fetch stage expressed as its behavioural rules.
    function automatic snap_t model(input snap_t s, input logic r, input logic st, input logic b,
                                    input logic [63:0] t, input logic [31:0] w,
                                    input logic [63:0] last, input logic [63:0] rpc);
        snap_t n;
        n = s;
        if (r) begin
            n.pc = rpc; n.instr = NOP; n.ipc = 64'h0; n.valid = 1'b0;
            n.halted = 1'b0; n.fault = 1'b0; n.ipc_chk = 1'b1;
        end else if (b) begin
            n.instr = NOP; n.ipc = 64'h0; n.valid = 1'b0; n.ipc_chk = 1'b1;
            if (t[1:0] != 2'b00 || t > last) begin
                n.halted = 1'b1; n.fault = 1'b1;
            end else begin
                n.pc = t; n.halted = 1'b0; n.fault = 1'b0;
            end
        end else if (st) begin
            n = s;
        end else begin
            n.instr = NOP; n.valid = 1'b0; n.ipc_chk = 1'b0;
            if (s.halted) begin
                n.halted = 1'b1;
            end else if (s.pc[1:0] != 2'b00 || s.pc > last) begin
                n.halted = 1'b1; n.fault = 1'b1;
            end else if (w == 32'h0) begin
                n.halted = 1'b1; n.fault = 1'b0;
            end else begin
                n.instr = w; n.ipc = s.pc; n.valid = 1'b1; n.ipc_chk = 1'b1;
                n.pc = s.pc + 64'd4;
            end
        end
        return n;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the state expected after the next edge.
    task automatic cyc(input logic r, input logic st, input logic b, input logic [63:0] t);
        @(posedge clk);
        #2;
        reset = r; stall = st; br = b; tgt = t;
        ma = model(ma, r, st, b, t, rd_a(ma.pc), 64'd1020, 64'h40);
        mb = model(mb, r, st, b, t, rd_b(mb.pc), 64'd12, 64'h0);
        qa.push_back(ma);
        qb.push_back(mb);
    endtask

    // Monitor: after every edge that consumed stimulus, compare both DUTs to the queued model.
    initial begin
        snap_t ea, eb;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() != 0 && qb.size() != 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                check("a_pc", pc_a, ea.pc);
                check("a_imem_addr", addr_a, ea.pc);
                check("a_instr", {32'h0, instr_a}, {32'h0, ea.instr});
                check("a_valid", {63'h0, valid_a}, {63'h0, ea.valid});
                check("a_halted", {63'h0, halted_a}, {63'h0, ea.halted});
                check("a_fault", {63'h0, fault_a}, {63'h0, ea.fault});
                if (ea.ipc_chk) check("a_if_id_pc", ipc_a, ea.ipc);
                check("b_pc", pc_b, eb.pc);
                check("b_instr", {32'h0, instr_b}, {32'h0, eb.instr});
                check("b_valid", {63'h0, valid_b}, {63'h0, eb.valid});
                check("b_halted", {63'h0, halted_b}, {63'h0, eb.halted});
                check("b_fault", {63'h0, fault_b}, {63'h0, eb.fault});
                if (eb.ipc_chk) check("b_if_id_pc", ipc_b, eb.ipc);
            end
        end
    end

    initial begin
        logic [63:0] t;
        ma = '0;
        mb = '0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = (i % 13 == 12) ? 32'h0 : ($urandom() | 32'h1);
        end
        mem_a[0] = 32'h0050_0093;
        mem_a[1] = 32'h00A0_0113;
        mem_a[2] = 32'h0010_0193;
        mem_a[3] = 32'h0000_0000;
        mem_a[8] = 32'h0020_8233;
        mem_a[9] = 32'h0031_02B3;
        mem_b[0] = 32'h0050_0093;
        mem_b[1] = 32'h00A0_0113;
        mem_b[2] = 32'h0010_0193;
        mem_b[3] = 32'h0040_0213;

        cyc(1'b1, 1'b0, 1'b0, 64'h0);
        cyc(1'b1, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 1'b0, 1'b1, 64'h0);
        cyc(1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 1'b0, 1'b0, 64'h0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 64'h0);
        cyc(1'b0, 1'b0, 1'b0, 64'h0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 1'b1, 1'b1, 64'h20);
        cyc(1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 1'b0, 1'b1, 64'h22);
        cyc(1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 1'b0, 1'b1, 64'h0);
        cyc(1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b1, 1'b1, 1'b1, 64'h22);
        cyc(1'b0, 1'b0, 1'b1, 64'h3FC);
        cyc(1'b0, 1'b0, 1'b0, 64'h0);
        cyc(1'b0, 1'b0, 1'b0, 64'h0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: t = 64'($urandom_range(0, 255)) << 2;
                1: t = 64'($urandom_range(0, 3)) << 2;
                2: t = 64'h3FC;
                3: t = 64'h400;
                4: t = (64'($urandom_range(0, 255)) << 2) + 64'($urandom_range(1, 3));
                default: t = 64'hFFFF_FFFF_FFFF_FFFC;
            endcase
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0), t);
        end

        @(posedge clk);
        #2;
        reset = 1'b0; stall = 1'b0; br = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", qa.size() + qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
